// File: rtl/tlul_pkg.sv
// Minimal TL-UL type package: request/response structs and opcode encodings.
package tlul_pkg;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/peri_gpio_tlul.sv
// TL-UL GPIO peripheral: data out / output enable / masked writes and synchronised input readback.
// Optional edge interrupt (INTR_STATE, INTR_ENABLE, intr_o) is built only with GPIO_INTR_EN defined.
module peri_gpio_tlul
    import tlul_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter logic [31:0] DataOutRst = 32'h0,
    parameter logic [31:0] OeRst      = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  tl_h2d_t     tl_i,
    output tl_d2h_t     tl_o,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic [31:0] gpio_en_o
`ifdef GPIO_INTR_EN
    ,
    output logic        intr_o
`endif
);

    logic [SyncStages-1:0][31:0] sync_q;
    logic [31:0] data_in;
    logic [31:0] data_out_q, data_out_d;
    logic [31:0] oe_q, oe_d;

    logic        rsp_pend_q, rsp_pend_d;
    logic [2:0]  rsp_opcode_q, rsp_opcode_d;
    logic [1:0]  rsp_size_q, rsp_size_d;
    logic [7:0]  rsp_source_q, rsp_source_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_error_q, rsp_error_d;

    logic [11:0] addr;
    logic        is_get, is_put, accept;
    logic        err;
    logic [31:0] rd_data, wd, bmask;
    logic        wr_dout, wr_oe, wr_mlo, wr_mup;

    logic unused_tl;
    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:12]};

    assign addr    = tl_i.a_address[11:0];
    assign wd      = tl_i.a_data;
    assign bmask   = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                      {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
    assign is_get  = (tl_i.a_opcode == Get);
    assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    assign accept  = tl_i.a_valid && !rsp_pend_q;
    assign data_in = sync_q[SyncStages-1];

`ifdef GPIO_INTR_EN
    logic [31:0] intr_state_q, intr_state_d;
    logic [31:0] intr_en_q, intr_en_d;
    logic [31:0] prev_in_q;
    logic        intr_q;
    logic        wr_istate, wr_ien;
`endif

    always_comb begin
        rd_data = '0;
        err     = 1'b0;
        wr_dout = 1'b0;
        wr_oe   = 1'b0;
        wr_mlo  = 1'b0;
        wr_mup  = 1'b0;
`ifdef GPIO_INTR_EN
        wr_istate = 1'b0;
        wr_ien    = 1'b0;
`endif
        if (!(is_get || is_put) || (addr[1:0] != 2'b00)) begin
            err = 1'b1;
        end else begin
            case (addr)
                12'h000: begin
                    rd_data = data_in;
                    err     = is_put;
                end
                12'h004: begin
                    rd_data = data_out_q;
                    wr_dout = is_put;
                end
                12'h008: begin
                    rd_data = oe_q;
                    wr_oe   = is_put;
                end
                12'h00c: begin
                    rd_data = {16'h0, data_out_q[15:0]};
                    if (is_put) begin
                        err    = (tl_i.a_mask != 4'hf);
                        wr_mlo = (tl_i.a_mask == 4'hf);
                    end
                end
                12'h010: begin
                    rd_data = {16'h0, data_out_q[31:16]};
                    if (is_put) begin
                        err    = (tl_i.a_mask != 4'hf);
                        wr_mup = (tl_i.a_mask == 4'hf);
                    end
                end
`ifdef GPIO_INTR_EN
                12'h014: begin
                    rd_data   = intr_state_q;
                    wr_istate = is_put;
                end
                12'h018: begin
                    rd_data = intr_en_q;
                    wr_ien  = is_put;
                end
`endif
                default: err = 1'b1;
            endcase
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        oe_d       = oe_q;
        if (accept) begin
            if (wr_dout) data_out_d = (data_out_q & ~bmask) | (wd & bmask);
            if (wr_oe)   oe_d       = (oe_q & ~bmask) | (wd & bmask);
            // Upper half of the write word selects which lower-half bits take the new value.
            if (wr_mlo) begin
                data_out_d[15:0] = (data_out_q[15:0] & ~wd[31:16]) | (wd[15:0] & wd[31:16]);
            end
            if (wr_mup) begin
                data_out_d[31:16] = (data_out_q[31:16] & ~wd[31:16]) | (wd[15:0] & wd[31:16]);
            end
        end
    end

    always_comb begin
        rsp_pend_d   = rsp_pend_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_size_d   = rsp_size_q;
        rsp_source_d = rsp_source_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        if (accept) begin
            rsp_pend_d   = 1'b1;
            rsp_opcode_d = is_get ? AccessAckData : AccessAck;
            rsp_size_d   = tl_i.a_size;
            rsp_source_d = tl_i.a_source;
            rsp_data_d   = (is_get && !err) ? rd_data : 32'h0;
            rsp_error_d  = err;
        end else if (rsp_pend_q && tl_i.d_ready) begin
            rsp_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q       <= '0;
            data_out_q   <= DataOutRst;
            oe_q         <= OeRst;
            rsp_pend_q   <= 1'b0;
            rsp_opcode_q <= 3'h0;
            rsp_size_q   <= 2'h0;
            rsp_source_q <= 8'h0;
            rsp_data_q   <= 32'h0;
            rsp_error_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SyncStages-2:0], gpio_i};
            data_out_q   <= data_out_d;
            oe_q         <= oe_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_size_q   <= rsp_size_d;
            rsp_source_q <= rsp_source_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

`ifdef GPIO_INTR_EN
    // Edge set is OR-ed in last so it wins over a same-cycle clear.
    always_comb begin
        intr_state_d = intr_state_q;
        intr_en_d    = intr_en_q;
        if (accept && wr_istate) intr_state_d = intr_state_q & ~(wd & bmask);
        if (accept && wr_ien)    intr_en_d    = (intr_en_q & ~bmask) | (wd & bmask);
        intr_state_d = intr_state_d | (data_in & ~prev_in_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_state_q <= '0;
            intr_en_q    <= '0;
            prev_in_q    <= '0;
            intr_q       <= 1'b0;
        end else begin
            intr_state_q <= intr_state_d;
            intr_en_q    <= intr_en_d;
            prev_in_q    <= data_in;
            intr_q       <= |(intr_state_q & intr_en_q);
        end
    end

    assign intr_o = intr_q;
`endif

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = rsp_pend_q;
        tl_o.d_opcode = rsp_opcode_q;
        tl_o.d_size   = rsp_size_q;
        tl_o.d_source = rsp_source_q;
        tl_o.d_data   = rsp_data_q;
        tl_o.d_error  = rsp_error_q;
        tl_o.a_ready  = !rsp_pend_q;
    end

    assign gpio_o    = data_out_q;
    assign gpio_en_o = oe_q;

endmodule

// File: tb/tb_peri_gpio_tlul.sv
// Directed self-checking bench for peri_gpio_tlul with a response scoreboard queue.
module tb_peri_gpio_tlul;
    import tlul_pkg::*;

    localparam int unsigned Sync = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [2:0]  opc;
        logic [7:0]  src;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    tl_h2d_t     tl_i;
    tl_d2h_t     tl_o;
    logic [31:0] gpio_i, gpio_o, gpio_en_o;
`ifdef GPIO_INTR_EN
    logic        intr_o;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    logic [7:0]  src_id = 8'h0;
    logic [31:0] m_dout, m_oe;

    always #5 clk = ~clk;

    peri_gpio_tlul #(
        .SyncStages(Sync),
        .DataOutRst(32'h0),
        .OeRst     (32'h0)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .tl_i     (tl_i),
        .tl_o     (tl_o),
        .gpio_i   (gpio_i),
        .gpio_o   (gpio_o),
        .gpio_en_o(gpio_en_o)
`ifdef GPIO_INTR_EN
        ,
        .intr_o   (intr_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One transaction; called at posedge+1. Holds d_ready low for `hold` cycles after accept.
    task automatic tl_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wdata,
                          input logic [31:0] exp_d, input logic exp_e, input int hold);
        exp_t e, got;
        int   cnt;
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = op;
        tl_i.a_size    = 2'd2;
        tl_i.a_source  = src_id;
        tl_i.a_address = addr;
        tl_i.a_mask    = mask;
        tl_i.a_data    = wdata;
        tl_i.d_ready   = (hold == 0);
        e.data = exp_d;
        e.err  = exp_e;
        e.opc  = (op == Get) ? AccessAckData : AccessAck;
        e.src  = src_id;
        e.tag  = tag;
        sb_q.push_back(e);
        src_id++;
        cnt = 0;
        while (!tl_o.a_ready && cnt < 20) begin
            cyc(1);
            cnt++;
        end
        if (cnt >= 20) chk({tag, " a_ready timeout"}, {31'h0, tl_o.a_ready}, 32'h1);
        chk({tag, " d_valid before accept"}, {31'h0, tl_o.d_valid}, 32'h0);
        cyc(1);
        tl_i.a_valid = 1'b0;
        chk({tag, " d_valid 1 cycle after accept"}, {31'h0, tl_o.d_valid}, 32'h1);
        for (int i = 0; i < hold; i++) begin
            chk({tag, " held d_valid"}, {31'h0, tl_o.d_valid}, 32'h1);
            chk({tag, " held d_data"}, tl_o.d_data, sb_q[0].data);
            chk({tag, " held a_ready"}, {31'h0, tl_o.a_ready}, 32'h0);
            cyc(1);
        end
        tl_i.d_ready = 1'b1;
        cnt = 0;
        while (!tl_o.d_valid && cnt < 20) begin
            cyc(1);
            cnt++;
        end
        if (cnt >= 20) chk({tag, " d_valid timeout"}, {31'h0, tl_o.d_valid}, 32'h1);
        got = sb_q.pop_front();
        chk({got.tag, " d_data"}, tl_o.d_data, got.data);
        chk({got.tag, " d_error"}, {31'h0, tl_o.d_error}, {31'h0, got.err});
        chk({got.tag, " d_opcode"}, {29'h0, tl_o.d_opcode}, {29'h0, got.opc});
        chk({got.tag, " d_source"}, {24'h0, tl_o.d_source}, {24'h0, got.src});
        chk({got.tag, " d_size"}, {30'h0, tl_o.d_size}, 32'h2);
        cyc(1);
    endtask

    function automatic logic [31:0] bm(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tl_i = '0;
        tl_i.d_ready = 1'b1;
        gpio_i = 32'h0;
        m_dout = 32'h0;
        m_oe   = 32'h0;
        rst_n  = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        chk("reset gpio_o", gpio_o, 32'h0);
        chk("reset gpio_en_o", gpio_en_o, 32'h0);
        chk("reset d_valid", {31'h0, tl_o.d_valid}, 32'h0);
        chk("reset a_ready", {31'h0, tl_o.a_ready}, 32'h1);

        tl_req("get DATA_OUT rst", Get, 32'h4, 4'hf, 32'h0, 32'h0, 1'b0, 0);
        tl_req("get OE rst", Get, 32'h8, 4'hf, 32'h0, 32'h0, 1'b0, 0);

        tl_req("putfull DATA_OUT", PutFullData, 32'h4, 4'hf, 32'hA5A5_1234, 32'h0, 1'b0, 0);
        m_dout = 32'hA5A5_1234;
        chk("gpio_o after putfull", gpio_o, m_dout);
        tl_req("putpartial DATA_OUT", PutPartialData, 32'h4, 4'b0100, 32'h00FF_0000,
               32'h0, 1'b0, 0);
        m_dout = (m_dout & ~bm(4'b0100)) | (32'h00FF_0000 & bm(4'b0100));
        chk("gpio_o after putpartial", gpio_o, 32'hA5FF_1234);

        tl_req("putfull OE", PutFullData, 32'h8, 4'hf, 32'hFFFF_0000, 32'h0, 1'b0, 0);
        m_oe = 32'hFFFF_0000;
        chk("gpio_en_o after write", gpio_en_o, m_oe);
        tl_req("get OE", Get, 32'h8, 4'h1, 32'h0, m_oe, 1'b0, 0);

        tl_req("set DATA_OUT 0000FFFF", PutFullData, 32'h4, 4'hf, 32'h0000_FFFF, 32'h0, 1'b0, 0);
        tl_req("masked lower", PutFullData, 32'hC, 4'hf, 32'h00F0_0000, 32'h0, 1'b0, 0);
        m_dout = 32'h0000_FF0F;
        chk("gpio_o masked lower", gpio_o, m_dout);
        tl_req("get masked lower", Get, 32'hC, 4'hf, 32'h0, 32'h0000_FF0F, 1'b0, 0);
        tl_req("masked upper", PutFullData, 32'h10, 4'hf, 32'h8000_8000, 32'h0, 1'b0, 0);
        m_dout = 32'h8000_FF0F;
        chk("gpio_o masked upper", gpio_o, m_dout);
        tl_req("get masked upper", Get, 32'h10, 4'hf, 32'h0, 32'h0000_8000, 1'b0, 0);

        gpio_i = 32'hDEAD_BEEF;
        tl_req("get DATA_IN early", Get, 32'h0, 4'hf, 32'h0, 32'h0, 1'b0, 0);
        cyc(3);
        tl_req("get DATA_IN settled", Get, 32'h0, 4'hf, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        tl_req("err misaligned", Get, 32'h2, 4'hf, 32'h0, 32'h0, 1'b1, 0);
        tl_req("err unmapped", Get, 32'h40, 4'hf, 32'h0, 32'h0, 1'b1, 0);
        tl_req("err write DATA_IN", PutFullData, 32'h0, 4'hf, 32'h1234_5678, 32'h0, 1'b1, 0);
        tl_req("err masked partial", PutPartialData, 32'hC, 4'h3, 32'hFFFF_0000,
               32'h0, 1'b1, 0);
        tl_req("err bad opcode", 3'h2, 32'h4, 4'hf, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        tl_req("err misaligned put", PutFullData, 32'h5, 4'hf, 32'h0, 32'h0, 1'b1, 0);
`ifndef GPIO_INTR_EN
        tl_req("err INTR_STATE absent", Get, 32'h14, 4'hf, 32'h0, 32'h0, 1'b1, 0);
        tl_req("err INTR_ENABLE absent", PutFullData, 32'h18, 4'hf, 32'h1, 32'h0, 1'b1, 0);
`endif
        chk("gpio_o unchanged by errors", gpio_o, m_dout);
        chk("gpio_en_o unchanged by errors", gpio_en_o, m_oe);

        tl_req("d_ready held low", Get, 32'h4, 4'hf, 32'h0, m_dout, 1'b0, 5);

`ifdef GPIO_INTR_EN
        tl_req("enable intr0", PutFullData, 32'h18, 4'hf, 32'h1, 32'h0, 1'b0, 0);
        gpio_i[0] = 1'b0;
        cyc(Sync + 2);
        tl_req("clear intr state", PutFullData, 32'h14, 4'hf, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
        cyc(2);
        chk("intr_o cleared", {31'h0, intr_o}, 32'h0);
        gpio_i[0] = 1'b1;
        cyc(Sync + 3);
        tl_req("intr state set", Get, 32'h14, 4'hf, 32'h0, 32'h1, 1'b0, 0);
        chk("intr_o asserted", {31'h0, intr_o}, 32'h1);
        gpio_i[0] = 1'b0;
        cyc(Sync + 2);
        tl_req("clear again", PutFullData, 32'h14, 4'hf, 32'h1, 32'h0, 1'b0, 0);
        cyc(2);
        chk("intr_o cleared again", {31'h0, intr_o}, 32'h0);
        // Rising edge reaches the detector on the same edge the W1C is accepted.
        gpio_i[0] = 1'b1;
        cyc(Sync);
        tl_req("w1c vs edge", PutFullData, 32'h14, 4'hf, 32'h1, 32'h0, 1'b0, 0);
        tl_req("set wins over w1c", Get, 32'h14, 4'hf, 32'h0, 32'h1, 1'b0, 0);
        chk("intr_o after race", {31'h0, intr_o}, 32'h1);
`endif

        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = Get;
        tl_i.a_address = 32'h4;
        tl_i.a_mask    = 4'hf;
        tl_i.d_ready   = 1'b0;
        cyc(1);
        tl_i.a_valid = 1'b0;
        chk("pending before reset", {31'h0, tl_o.d_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("d_valid drops on reset", {31'h0, tl_o.d_valid}, 32'h0);
        chk("gpio_o reset mid-txn", gpio_o, 32'h0);
        chk("gpio_en_o reset mid-txn", gpio_en_o, 32'h0);
`ifdef GPIO_INTR_EN
        chk("intr_o reset mid-txn", {31'h0, intr_o}, 32'h0);
`endif
        tl_i.d_ready = 1'b1;
        cyc(2);
        rst_n = 1'b1;
        m_dout = 32'h0;
        cyc(1);
        chk("a_ready after reset", {31'h0, tl_o.a_ready}, 32'h1);
        tl_req("get DATA_OUT after reset", Get, 32'h4, 4'hf, 32'h0, m_dout, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
